ws2812b_bus_feeder: RTL and testbench

//  Memory-mapped front end for the single-LED WS2812B serializer. The CPU writes 24-bit GRB words

---
 rtl/ws2812b_pkg.sv | 28 ++
 rtl/ws2812b_word_fifo.sv | 73 +++++++
 rtl/ws2812b_bus_feeder.sv | 177 +++++++++++++++++
 tb/tb_ws2812b_bus_feeder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
`timescale 1ns/1ps
// ws2812b_pkg
// Shared definitions for the WS2812B bus feeder: register word offsets,
// STATUS bit positions, control bit positions and the bus-side FSM states.
package ws2812b_pkg;

  // Register word offsets (bus_addr = mem_addr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BRIGHT = 2'd2;

  // STATUS read-back bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_IDLE      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  // STATUS write control bits
  localparam int CTL_FLUSH   = 0;
  localparam int CTL_OVF_CLR = 3;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/ws2812b_word_fifo.sv
`timescale 1ns/1ps
// ws2812b_word_fifo
// Synchronous FIFO of GRB words with first-word-fall-through head output.
// A push while full is only taken when a pop happens in the same cycle.
// Flush overrides any push/pop in the same cycle and leaves the FIFO empty.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push, din      write request and word
//   pop            read request (ignored when empty)
//   flush          discard all entries
//   empty, full    occupancy flags
//   count          entries held, 0..DEPTH (AW+1 bits)
//   head           oldest word (valid while !empty)
module ws2812b_word_fifo #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ws2812b_bus_feeder.sv
`timescale 1ns/1ps
// ws2812b_bus_feeder
// Memory-mapped front end for the single-LED WS2812B serializer. The CPU
// writes GRB words into a FIFO; words are handed to the serializer one at a
// time through the can_accept/ena handshake.
// Optional feature: define WS2812B_BRIGHTNESS_EN to add the BRIGHT register
// (offset 2) and a per-channel (c*bright)>>8 scaler on led_data.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   bus_valid        decoded request
//   bus_addr         word offset
//   bus_wstrb        byte enables, 0 = read
//   bus_wdata        write data
//   bus_rdata        read data, valid while bus_ready
//   bus_ready        one-cycle completion pulse
//   led_can_accept   serializer idle
//   led_ena          word presented (serializer latches on this edge)
//   led_data         {G,R,B}
module ws2812b_bus_feeder
  import ws2812b_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic [1:0]  bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        led_can_accept,
  output logic        led_ena,
  output logic [23:0] led_data
);

  bus_state_e     state_q;
  bus_state_e     state_d;
  logic           accept_p0;
  logic           wr_p0;
  logic [23:0]    push_word_p0;
  logic           push_req;
  logic           push_ok;
  logic           flush;
  logic           ovf_clr;
  logic           empty;
  logic           full;
  logic [FIFO_AW:0] count;
  logic [23:0]    head;
  logic           idle;
  logic [23:0]    shadow_q;
  logic           overflow_q;
  logic [31:0]    status_word;
  logic [31:0]    read_word;
  logic [31:0]    rdata_p1;
  logic           unused_bits;

  // Per-channel brightness scale; 255*255 gives 254 by construction.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = c * b;
    return p[15:8];
  endfunction

  assign unused_bits = ^{bus_wdata[31:24], bus_wstrb[3]};

  // Bus FSM: IDLE accepts, RESP drives the ready pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus_ready = 1'b0;
    case (state_q)
      BUS_IDLE: if (bus_valid) state_d = BUS_RESP;
      BUS_RESP: begin
        bus_ready = 1'b1;
        state_d   = BUS_IDLE;
      end
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Stage p0: request decode
  assign accept_p0    = (state_q == BUS_IDLE) & bus_valid;
  assign wr_p0        = accept_p0 & (|bus_wstrb);
  assign push_word_p0 = {bus_wstrb[2] ? bus_wdata[23:16] : 8'h00,
                         bus_wstrb[1] ? bus_wdata[15:8]  : 8'h00,
                         bus_wstrb[0] ? bus_wdata[7:0]   : 8'h00};
  assign push_req = wr_p0 & (bus_addr == REG_DATA);
  assign flush    = wr_p0 & (bus_addr == REG_STATUS) & bus_wdata[CTL_FLUSH];
  assign ovf_clr  = wr_p0 & (bus_addr == REG_STATUS) & bus_wdata[CTL_OVF_CLR];

  // A full FIFO still takes the word when the serializer pops in the same cycle.
  assign push_ok = push_req & (~full | led_ena);

  assign led_ena = led_can_accept & ~empty;
  assign idle    = empty & led_can_accept;

  ws2812b_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .AW     (FIFO_AW),
    .DATA_W (24)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .din     (push_word_p0),
    .pop     (led_ena),
    .flush   (flush),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .head    (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) shadow_q <= push_word_p0;
      if (push_req && !push_ok) overflow_q <= 1'b1;
      else if (ovf_clr)         overflow_q <= 1'b0;
    end
  end

  always_comb begin
    status_word                       = '0;
    status_word[ST_EMPTY]             = empty;
    status_word[ST_FULL]              = full;
    status_word[ST_IDLE]              = idle;
    status_word[ST_OVF]               = overflow_q;
    status_word[ST_COUNT_LSB +: 8]    = 8'(count);
  end

`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0] bright_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bright_q <= 8'hFF;
    else if (wr_p0 && bus_addr == REG_BRIGHT && bus_wstrb[0]) bright_q <= bus_wdata[7:0];
  end

  assign led_data = {scale_chan(head[23:16], bright_q),
                     scale_chan(head[15:8],  bright_q),
                     scale_chan(head[7:0],   bright_q)};
`else
  assign led_data = head;
`endif

  always_comb begin
    read_word = '0;
    case (bus_addr)
      REG_DATA:   read_word = {8'h00, shadow_q};
      REG_STATUS: read_word = status_word;
`ifdef WS2812B_BRIGHTNESS_EN
      REG_BRIGHT: read_word = {24'h0, bright_q};
`else
      REG_BRIGHT: read_word = '0;
`endif
      default:    read_word = '0;
    endcase
  end

  // Stage p1: registered read data, presented with bus_ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       rdata_p1 <= '0;
    else if (accept_p0) rdata_p1 <= read_word;
  end

  assign bus_rdata = rdata_p1;

endmodule

// File: tb/tb_ws2812b_bus_feeder.sv
`timescale 1ns/1ps
module tb_ws2812b_bus_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bus_valid;
  logic [1:0]  bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        led_can_accept;
  logic        led_ena;
  logic [23:0] led_data;

  int checks = 0;
  int errors = 0;
  logic [23:0] seen[$];
  logic [31:0] rd;
  logic        rdy;

`ifdef WS2812B_BRIGHTNESS_EN
  localparam logic BR = 1'b1;
`else
  localparam logic BR = 1'b0;
`endif

  always #5 clk = ~clk;

  ws2812b_bus_feeder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus_valid      (bus_valid),
    .bus_addr       (bus_addr),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ready      (bus_ready),
    .led_can_accept (led_can_accept),
    .led_ena        (led_ena),
    .led_data       (led_data)
  );

  // Serializer model: a word is latched on the edge following a negedge where ena is high.
  always @(negedge clk) begin
    if (reset_n && led_ena) seen.push_back(led_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_addr  = a;
    bus_wdata = d;
    bus_wstrb = s;
    bus_valid = 1'b1;
    step(1);
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    step(1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic r);
    bus_addr  = a;
    bus_wstrb = 4'h0;
    bus_valid = 1'b1;
    step(1);
    bus_valid = 1'b0;
    d = bus_rdata;
    r = bus_ready;
    step(1);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus_valid      = 1'b0;
    bus_addr       = 2'd0;
    bus_wstrb      = 4'h0;
    bus_wdata      = 32'h0;
    led_can_accept = 1'b1;

    // Reset state
    step(2);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_ena", {31'h0, led_ena}, 32'h0);
    check("rst_ready", {31'h0, bus_ready}, 32'h0);
    reset_n = 1'b1;
    step(1);
    bus_read(2'd1, rd, rdy);
    check("rst_status", rd, 32'h0000_0005);
    check("read_ready", {31'h0, rdy}, 32'h1);

    // Single word through the handshake
    seen.delete();
    bus_write(2'd0, 32'h00FF8010, 4'hF);
    check("one_word_cnt", seen.size(), 32'd1);
    check("one_word_val", {8'h0, seen[0]}, 32'h00FF8010);
    check("one_word_ena_low", {31'h0, led_ena}, 32'h0);
    bus_read(2'd0, rd, rdy);
    check("shadow_rd", rd, 32'h00FF8010);

    // Partial byte enables zero the disabled bytes
    seen.delete();
    bus_write(2'd0, 32'h11AABBCC, 4'b0101);
    check("strb_cnt", seen.size(), 32'd1);
    check("strb_val", {8'h0, seen[0]}, 32'h00AA00CC);

    // Overfill with serializer stalled
    led_can_accept = 1'b0;
    seen.delete();
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h00A05000 + i, 4'hF);
    bus_read(2'd1, rd, rdy);
    check("full_status", rd, 32'h0000_080A);
    bus_read(2'd0, rd, rdy);
    check("full_shadow", rd, 32'h00A05007);
    check("stall_no_out", seen.size(), 32'd0);
    led_can_accept = 1'b1;
    step(12);
    check("drain_cnt", seen.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("drain_order", {8'h0, seen[i]}, 32'h00A05000 + i);
    bus_read(2'd1, rd, rdy);
    check("ovf_sticky", rd, 32'h0000_000D);
    bus_write(2'd1, 32'h8, 4'hF);
    bus_read(2'd1, rd, rdy);
    check("ovf_clear", rd, 32'h0000_0005);

    // Push and pop in the same cycle while full
    led_can_accept = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h00B00000 + i, 4'hF);
    seen.delete();
    bus_addr = 2'd0; bus_wdata = 32'h00B00008; bus_wstrb = 4'hF; bus_valid = 1'b1;
    led_can_accept = 1'b1;
    step(1);
    bus_valid = 1'b0; bus_wstrb = 4'h0; led_can_accept = 1'b0;
    step(1);
    check("pp_popped", seen.size(), 32'd1);
    check("pp_pop_val", {8'h0, seen[0]}, 32'h00B00000);
    bus_read(2'd1, rd, rdy);
    check("pp_status", rd, 32'h0000_0802);
    bus_read(2'd0, rd, rdy);
    check("pp_shadow", rd, 32'h00B00008);

    // Flush in the same cycle as a pop
    bus_addr = 2'd1; bus_wdata = 32'h1; bus_wstrb = 4'hF; bus_valid = 1'b1;
    led_can_accept = 1'b1;
    step(1);
    bus_valid = 1'b0; bus_wstrb = 4'h0; led_can_accept = 1'b0;
    step(1);
    check("flush_popped", seen.size(), 32'd2);
    check("flush_pop_val", {8'h0, seen[1]}, 32'h00B00001);
    bus_read(2'd1, rd, rdy);
    check("flush_status", rd, 32'h0000_0001);

    // Reset mid-drain
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h00C00000 + i, 4'hF);
    led_can_accept = 1'b1;
    step(1);
    reset_n = 1'b0;
    #1;
    check("midrst_ena", {31'h0, led_ena}, 32'h0);
    check("midrst_rdata", bus_rdata, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    bus_read(2'd1, rd, rdy);
    check("midrst_status", rd, 32'h0000_0005);
    bus_read(2'd2, rd, rdy);
    check("midrst_bright", rd, BR ? 32'h0000_00FF : 32'h0);

    // Brightness scaling
    led_can_accept = 1'b0;
    bus_write(2'd2, 32'h80, 4'hF);
    bus_read(2'd2, rd, rdy);
    check("bright_rd", rd, BR ? 32'h0000_0080 : 32'h0);
    bus_write(2'd0, 32'h00FF4002, 4'hF);
    check("scale_80", {8'h0, led_data}, BR ? 32'h007F2001 : 32'h00FF4002);
    bus_write(2'd2, 32'hFF, 4'hF);
    check("scale_ff", {8'h0, led_data}, BR ? 32'h00FE3F01 : 32'h00FF4002);

    // Reserved offset
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(2'd3, rd, rdy);
    check("rsvd_rd", rd, 32'h0);
    check("rsvd_ready", {31'h0, rdy}, 32'h1);
    bus_read(2'd1, rd, rdy);
    check("rsvd_status", rd, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
